// File: rtl/adder_operand_loader.sv
// Operand loader for the wide adder stage: packs a narrow word stream into
// two wide operands plus carry-in and presents them as a single transaction
// over a valid/ready handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// S_A   | collecting operand A words, least-significant word first
// S_B   | collecting operand B words; final beat also captures carry-in
// S_OUT | transaction complete and held stable until the consumer accepts
module adder_operand_loader #(
    parameter int OP_W   = 100,
    parameter int WORD_W = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_cin,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [OP_W-1:0]   op_a,
    output logic [OP_W-1:0]   op_b,
    output logic              op_cin,
    output logic              busy
);

    localparam int BEATS = OP_W / WORD_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Operands are built from whole words only; a partial top word is rejected.
    if ((OP_W % WORD_W) != 0) begin : g_width_check
        $error("adder_operand_loader: OP_W must be an exact multiple of WORD_W");
    end

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OUT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;
    logic             handoff;
    logic             last_beat;

    // Next-state, beat counter and handshake outputs; clr overrides everything.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = beat_cnt;
        in_ready  = rst_n && (state != S_OUT);
        op_valid  = (state == S_OUT);
        accept    = in_valid && in_ready;
        handoff   = op_valid && op_ready;
        last_beat = (beat_cnt == CNT_W'(BEATS - 1));

        case (state)
            S_A: begin
                if (accept) begin
                    if (last_beat) begin
                        cnt_nxt   = '0;
                        state_nxt = S_B;
                    end else begin
                        cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            S_B: begin
                if (accept) begin
                    if (last_beat) begin
                        cnt_nxt   = '0;
                        state_nxt = S_OUT;
                    end else begin
                        cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (handoff) begin
                    cnt_nxt   = '0;
                    state_nxt = S_A;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_A;
            end
        endcase

        if (clr) begin
            cnt_nxt   = '0;
            state_nxt = S_A;
        end
    end

    // State register; reset and clr both wipe the FSM and the counter.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state    <= S_A;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= cnt_nxt;
        end
    end

    // Operand packing and busy flag; operands persist after handoff.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            op_a   <= '0;
            op_b   <= '0;
            op_cin <= 1'b0;
            busy   <= 1'b0;
        end else begin
            if (accept && (state == S_A)) begin
                busy <= 1'b1;
                for (int k = 0; k < BEATS; k++) begin
                    if (beat_cnt == CNT_W'(k)) begin
                        op_a[k*WORD_W +: WORD_W] <= in_data;
                    end
                end
            end
            if (accept && (state == S_B)) begin
                for (int k = 0; k < BEATS; k++) begin
                    if (beat_cnt == CNT_W'(k)) begin
                        op_b[k*WORD_W +: WORD_W] <= in_data;
                    end
                end
                if (last_beat) begin
                    op_cin <= in_cin;
                end
            end
            if (handoff) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder_operand_loader.sv
// Testbench for adder_operand_loader: directed loads with a scoreboard
// queue of expected transactions and a monitor that checks each handoff.
module tb_adder_operand_loader;

    localparam int OP_W   = 100;
    localparam int WORD_W = 25;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic            cin;
    } txn_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_cin;
    logic              op_valid;
    logic              op_ready;
    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic              op_cin;
    logic              busy;

    int   n_pass = 0;
    int   n_total = 0;
    int   handoffs = 0;
    int   cyc = 0;
    txn_t exp_q[$];

    adder_operand_loader #(.OP_W(OP_W), .WORD_W(WORD_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_cin   (in_cin),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_cin   (op_cin),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: a handoff happens at the next rising edge when this holds.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && clr === 1'b0 && op_valid === 1'b1 && op_ready === 1'b1) begin
            txn_t e;
            handoffs++;
            if (exp_q.size() == 0) begin
                chk("unexpected_handoff", 128'd1, 128'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_op_a", 128'(op_a), 128'(e.a));
                chk("sb_op_b", 128'(op_b), 128'(e.b));
                chk("sb_op_cin", 128'(op_cin), 128'(e.cin));
            end
        end
    end

    // Drives all eight beats; gap inserts an idle cycle between beats.
    task automatic load(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                        input logic cin_last, input logic cin_other, input bit gap,
                        output int first_cyc, output int last_cyc);
        first_cyc = 0;
        last_cyc  = 0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = (k < 4) ? a[k*WORD_W +: WORD_W] : b[(k-4)*WORD_W +: WORD_W];
            in_cin   = (k == 7) ? cin_last : cin_other;
            if (k == 0) first_cyc = cyc;
            if (k == 7) last_cyc = cyc;
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_cin   = cin_other;
            if (gap && k != 7) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (op_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (op_valid !== 1'b1) chk({name, "_timeout"}, 128'd0, 128'd1);
    endtask

    task automatic do_handoff(input string name);
        op_ready = 1'b1;
        @(posedge clk); #1;
        op_ready = 1'b0;
        chk({name, "_valid_after"}, 128'(op_valid), 128'd0);
        chk({name, "_ready_after"}, 128'(in_ready), 128'd1);
        chk({name, "_busy_after"}, 128'(busy), 128'd0);
    endtask

    initial begin
        int f, l;
        logic [OP_W-1:0] a_snap, b_snap;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_cin = 1'b0; op_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_op_valid", 128'(op_valid), 128'd0);
        chk("rst_op_a", 128'(op_a), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", 128'(in_ready), 128'd1);

        // Test 1: back-to-back stream, latency 8
        exp_q.push_back('{a: {25'h4, 25'h3, 25'h2, 25'h1}, b: {100{1'b1}}, cin: 1'b1});
        load({25'h4, 25'h3, 25'h2, 25'h1}, {4{25'h1FFFFFF}}, 1'b1, 1'b0, 1'b0, f, l);
        wait_valid("t1");
        chk("t1_latency", 128'(cyc - f), 128'd8);
        chk("t1_op_a", 128'(op_a), 128'({25'h4, 25'h3, 25'h2, 25'h1}));
        chk("t1_op_b", 128'(op_b), 128'({100{1'b1}}));
        chk("t1_op_cin", 128'(op_cin), 128'd1);
        chk("t1_busy", 128'(busy), 128'd1);

        // Test 2: backpressure for 5 cycles
        a_snap = op_a; b_snap = op_b;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 25'h0DEAD;
            @(posedge clk); #1;
            chk("t2_valid_hold", 128'(op_valid), 128'd1);
            chk("t2_a_hold", 128'(op_a), 128'(a_snap));
            chk("t2_b_hold", 128'(op_b), 128'(b_snap));
            chk("t2_in_ready_low", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        do_handoff("t2");

        // Test 3: gapped input
        exp_q.push_back('{a: {25'h4, 25'h3, 25'h2, 25'h1}, b: {100{1'b1}}, cin: 1'b1});
        load({25'h4, 25'h3, 25'h2, 25'h1}, {4{25'h1FFFFFF}}, 1'b1, 1'b0, 1'b1, f, l);
        wait_valid("t3");
        chk("t3_latency_last", 128'(cyc - l), 128'd1);
        chk("t3_op_a", 128'(op_a), 128'({25'h4, 25'h3, 25'h2, 25'h1}));
        chk("t3_op_b", 128'(op_b), 128'({100{1'b1}}));
        do_handoff("t3");

        // Test 4: in_cin only sampled on final B beat
        exp_q.push_back('{a: {25'h1555555, 25'h0000000, 25'h1000000, 25'h0ABCDEF},
                          b: {25'h0000001, 25'h1FFFFFF, 25'h00000FF, 25'h0F0F0F0}, cin: 1'b0});
        load({25'h1555555, 25'h0000000, 25'h1000000, 25'h0ABCDEF},
             {25'h0000001, 25'h1FFFFFF, 25'h00000FF, 25'h0F0F0F0}, 1'b0, 1'b1, 1'b0, f, l);
        wait_valid("t4");
        chk("t4_op_cin", 128'(op_cin), 128'd0);
        do_handoff("t4");
        in_cin = 1'b0;

        // Test 5: clr after two A beats, with a beat presented during clr
        in_valid = 1'b1; in_data = 25'h1AAAAAA;
        @(posedge clk); #1;
        in_data = 25'h1BBBBBB;
        @(posedge clk); #1;
        chk("t5_busy_before", 128'(busy), 128'd1);
        clr = 1'b1; in_data = 25'h1CCCCCC;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        chk("t5_busy_after_clr", 128'(busy), 128'd0);
        chk("t5_op_a_cleared", 128'(op_a), 128'd0);
        exp_q.push_back('{a: {4{25'h0000005}}, b: {25'h9, 25'h8, 25'h7, 25'h6}, cin: 1'b1});
        load({4{25'h0000005}}, {25'h9, 25'h8, 25'h7, 25'h6}, 1'b1, 1'b0, 1'b0, f, l);
        wait_valid("t5");
        chk("t5_op_a", 128'(op_a), 128'({4{25'h0000005}}));
        chk("t5_op_b", 128'(op_b), 128'({25'h9, 25'h8, 25'h7, 25'h6}));
        do_handoff("t5");

        // Test 6: reset while a transaction is being accepted
        load({4{25'h1234567}}, {4{25'h0765432}}, 1'b1, 1'b0, 1'b0, f, l);
        wait_valid("t6");
        rst_n = 1'b0; op_ready = 1'b1;
        @(posedge clk); #1;
        op_ready = 1'b0;
        chk("t6_op_valid", 128'(op_valid), 128'd0);
        chk("t6_op_a", 128'(op_a), 128'd0);
        chk("t6_op_b", 128'(op_b), 128'd0);
        rst_n = 1'b1;
        #1;
        chk("t6_in_ready", 128'(in_ready), 128'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 128'(exp_q.size()), 128'd0);
        chk("handoff_count", 128'(handoffs), 128'd4);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adder_operand_loader.md
Name: adder_operand_loader

Overview:
- Upstream feeder for the 100-bit adder stage.
- Assembles two wide operands (A, B) plus carry-in from a narrow word stream, then presents them as one stable transaction with a valid/ready handshake.
- Lets the wide adder be driven from a narrow bus or stimulus source without 200+ parallel input wires.

Parameters:
- OP_W, 100: operand width; width of op_a / op_b.
- WORD_W, 25: input word width. OP_W must be an exact multiple of WORD_W; otherwise elaboration fails via a generate-time check.
- BEATS, OP_W/WORD_W (derived localparam, 4): beats per operand.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- clr  in  1  synchronous flush; aborts any partial load.
- in_valid  in  1  in_data/in_cin valid this cycle.
- in_ready  out  1  loader can accept a beat.
- in_data  in  WORD_W  operand word, least-significant word first.
- in_cin  in  1  carry-in; sampled only on the final B beat.
- op_valid  out  1  op_a/op_b/op_cin hold a complete transaction.
- op_ready  in  1  downstream adder/consumer accepts the transaction.
- op_a  out  OP_W  assembled operand A.
- op_b  out  OP_W  assembled operand B.
- op_cin  out  1  assembled carry-in.
- busy  out  1  at least one beat accepted and the transaction not yet handed off.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=S_A, beat_cnt=0.
  - op_a=0, op_b=0, op_cin=0, op_valid=0, busy=0.
  - in_ready forced 0 while rst_n is low.
- Beat acceptance:
  - A beat is accepted when in_valid && in_ready.
  - in_ready = 1 in S_A and S_B; 0 in S_OUT.
- State S_A:
  - Each accepted beat writes in_data into op_a[beat_cnt*WORD_W +: WORD_W].
  - On beat BEATS-1: beat_cnt wraps to 0 and state moves to S_B; otherwise beat_cnt increments.
- State S_B:
  - Same, writing op_b.
  - The final beat (beat_cnt=BEATS-1) also captures op_cin <= in_cin; state moves to S_OUT.
  - in_cin is ignored on every other beat.
- State S_OUT:
  - op_valid=1 (registered; asserted the cycle after the final B beat is accepted).
  - op_a/op_b/op_cin are stable while op_valid=1 && op_ready=0.
  - Handoff happens when op_valid && op_ready. Next cycle: op_valid=0, state=S_A, beat_cnt=0, in_ready=1.
  - op_a/op_b/op_cin are not cleared after handoff and hold their last values until overwritten.
- No overlap:
  - A new A beat cannot be accepted in the same cycle as the handoff.
  - Minimum period = 2*BEATS+1 cycles per transaction (9 at defaults).
  - Latency from first A beat to op_valid = 2*BEATS cycles when in_valid is held high.
- Stalls:
  - in_valid may drop between beats in any state; beat_cnt and state hold.
  - op_ready is a don't-care outside S_OUT.
- busy:
  - Set on the first accepted A beat.
  - Cleared on handoff, clr, or reset.
  - Equals 1 throughout S_OUT.
- clr (evaluated only when rst_n=1):
  - Highest priority over both handshakes in the same cycle.
  - Next state: S_A, beat_cnt=0, op_valid=0, busy=0, op_a=op_b=0, op_cin=0.
  - A beat presented in the clr cycle is discarded, even if in_valid && in_ready.
  - A transaction in S_OUT is dropped even if op_ready=1 that cycle; the consumer must not count it.
- Reset mid-operation behaves identically to clr and restores all reset values.
- Widths:
  - No arithmetic; pure packing.
  - Word k occupies bits [k*WORD_W+WORD_W-1 : k*WORD_W]; word 0 is the LSBs.
  - beat_cnt width = $clog2(BEATS), minimum 1.

Test Plan:
1. Reset then a back-to-back stream:
   - Input: A words 0x0000001,0x0000002,0x0000003,0x0000004; B words 0x1FFFFFF x4; in_cin=1 on the last B beat.
   - Required: op_valid rises exactly 8 cycles after the first beat.
   - Required: op_a = {25'h4,25'h3,25'h2,25'h1}, op_b = all-ones (100 bits), op_cin=1.
2. Output backpressure:
   - Stimulus: hold op_ready=0 for 5 cycles in S_OUT.
   - Required: op_valid, op_a, op_b stay constant and in_ready=0 throughout.
   - Required: op_valid falls and in_ready rises the cycle after op_ready=1.
3. Input gaps:
   - Stimulus: toggle in_valid 1,0,1,0 across all 8 beats.
   - Required: same op_a/op_b as in test 1; op_valid rises one cycle after the 8th accepted beat.
4. in_cin filtering:
   - Stimulus: in_cin=1 on all beats except the final B beat, where it is 0.
   - Required: op_cin=0.
5. clr mid-load:
   - Stimulus: assert clr after 2 A beats, then load a full new transaction with A=0x…5 words.
   - Required: busy drops the cycle after clr; op_a contains only the new words; the abandoned beats have no effect.
6. Reset in S_OUT:
   - Stimulus: drive rst_n=0 for 1 cycle while op_valid=1 and op_ready=1.
   - Required: op_valid=0 and op_a=op_b=0 next cycle, with no handoff counted.
   - Required: in_ready=1 once rst_n=1.
